rom_window_scanner: RTL

- Downstream consumer of the 64x64 image ROM. Walks ROM addresses in raster order and buffers two previous rows in line buffers.
- Emits a stream of 3x3 pixel windows over a valid/ready handshake for the single-kernel convolution stage.
- Produces only interior windows: centre (y,x) with 1 <= y <= IMG_H-2 and 1 <= x <= IMG_W-2. At defaults that is 62x62 = 3844 windows per frame.

---
 rtl/img_pipeline_pkg.sv | 16 +
 rtl/line_buffer.sv | 25 ++
 rtl/rom_window_scanner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/img_pipeline_pkg.sv
// Shared constants and scanner state encoding for the image pipeline.
package img_pipeline_pkg;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int PIX_W  = 13;
  localparam int ADDR_W = 12;
  localparam int WIN_N  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; the asynchronous read returns the old word
// at the address being written, so a shift through two buffers needs one cycle.
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/rom_window_scanner.sv
// Raster-scans the image ROM and streams interior 3x3 windows over valid/ready.
// Optional centre-coordinate outputs are enabled by ROM_WINDOW_SCANNER_COORD_EN.
module rom_window_scanner #(
  parameter int IMG_W  = img_pipeline_pkg::IMG_W,
  parameter int IMG_H  = img_pipeline_pkg::IMG_H,
  parameter int PIX_W  = img_pipeline_pkg::PIX_W,
  parameter int ADDR_W = img_pipeline_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_last
`ifdef ROM_WINDOW_SCANNER_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  import img_pipeline_pkg::*;

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  scan_state_t      state_reg, state_next;
  logic [X_W-1:0]   col_reg;
  logic [Y_W-1:0]   row_reg;
  logic [PIX_W-1:0] win_reg [WIN_N];
  logic             win_valid_reg;
  logic             win_last_reg;
  logic             done_reg;

  logic             advance;
  logic             consume;
  logic             handshake;
  logic             at_last_pixel;
  logic             at_row_end;
  logic             emit;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  assign advance       = !win_valid_reg || win_ready;
  assign consume       = (state_reg == SCAN) && advance;
  assign handshake     = win_valid_reg && win_ready;
  assign at_row_end    = (col_reg == X_W'(IMG_W - 1));
  assign at_last_pixel = at_row_end && (row_reg == Y_W'(IMG_H - 1));
  // Once the third row and third column have arrived the window is interior.
  assign emit          = (row_reg >= Y_W'(2)) && (col_reg >= X_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (consume && at_last_pixel) state_next = DRAIN;
      DRAIN:   if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (consume) begin
      if (at_row_end) begin
        col_reg <= '0;
        row_reg <= (row_reg == Y_W'(IMG_H - 1)) ? '0 : row_reg + Y_W'(1);
      end else begin
        col_reg <= col_reg + X_W'(1);
      end
    end
  end

  // Window shift: columns move left, the new right column is the pixel column
  // at col from two rows up (lb1), one row up (lb0) and the current ROM word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIN_N; k++) begin
        win_reg[k] <= '0;
      end
    end else if (consume) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[3*r]     <= win_reg[3*r + 1];
        win_reg[3*r + 1] <= win_reg[3*r + 2];
      end
      win_reg[2] <= lb1_rd;
      win_reg[5] <= lb0_rd;
      win_reg[8] <= rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == DRAIN) && handshake;
      if (consume) begin
        win_valid_reg <= emit;
        win_last_reg  <= at_last_pixel;
      end else if (handshake) begin
        win_valid_reg <= 1'b0;
        win_last_reg  <= 1'b0;
      end
    end
  end

`ifdef ROM_WINDOW_SCANNER_COORD_EN
  logic [X_W-1:0] win_x_reg;
  logic [Y_W-1:0] win_y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_x_reg <= '0;
      win_y_reg <= '0;
    end else if (consume) begin
      win_x_reg <= col_reg - X_W'(1);
      win_y_reg <= row_reg - Y_W'(1);
    end
  end

  assign win_x = win_x_reg;
  assign win_y = win_y_reg;
`endif

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (consume),
    .addr    (col_reg),
    .wr_data (rom_data),
    .rd_data (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (consume),
    .addr    (col_reg),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  for (genvar gi = 0; gi < WIN_N; gi++) begin : g_pack
    assign win_data[gi*PIX_W +: PIX_W] = win_reg[gi];
  end

  assign rom_addr  = ADDR_W'(row_reg) * ADDR_W'(IMG_W) + ADDR_W'(col_reg);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign win_valid = win_valid_reg;
  assign win_last  = win_last_reg;

endmodule
